pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EX_CNT_W, default 5: width of the multi-cycle EX op length.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 64: maximum MEM_WAIT cycles before timeout (used only with the macro).
REQ-003 SHALL have parameter EXC_VECTOR, default 32'hBFC00380: redirect PC on timeout (used only with the macro).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 stallreq_id  in  1  load-use hazard request from ID.
REQ-007 ex_multi_start  in  1  EX begins a multi-cycle op.
REQ-008 ex_multi_cycles  in  EX_CNT_W  op length N; 0 is treated as 1.
REQ-009 mem_req  in  1  MEM stage issues a data access.
REQ-010 mem_ready  in  1  memory acknowledge.
REQ-011 flush_req  in  1  exception/redirect request.
REQ-012 flush_pc  in  32  redirect target.
REQ-013 stall  out  6  {reserved, mem/wb, ex/mem, id/ex, if/id, pc}; a set bit holds that register.
REQ-014 flush  out  1  registered one-cycle pulse that clears all pipeline registers.
REQ-015 new_pc  out  32  registered redirect PC; valid while flush=1.
REQ-016 ctrl_state  out  2  current FSM state encoding.
REQ-017 timeout_err  out  1  sticky MEM timeout flag; tied 0 without the macro.

Function
REQ-018 FSM states SHALL be IDLE=0, EX_BUSY=1, MEM_WAIT=2, FLUSH=3; stall SHALL be combinational from the state and inputs.
REQ-019 Stall codes SHALL be: ID=6'b000111, EX=6'b001111, MEM=6'b011111, none=6'b000000.
  - Where stall[k]=1 and stall[k+1]=0, the downstream pipeline register loads a bubble.
REQ-020 In IDLE, the highest-priority request SHALL win: flush_req > (mem_req & !mem_ready) > ex_multi_start > stallreq_id.
REQ-021 IDLE & flush_req SHALL go to FLUSH and capture new_pc<=flush_pc; stall=0 in that cycle.
REQ-022 IDLE & mem_req & !mem_ready SHALL output the MEM code in the same cycle and go to MEM_WAIT.
  - mem_req & mem_ready in the same cycle: no stall, stay in IDLE.
REQ-023 MEM_WAIT SHALL output the MEM code while mem_ready=0.
  - On the cycle mem_ready=1: stall=0, next state IDLE (or FLUSH if a flush is pending).
REQ-024 flush_req during MEM_WAIT SHALL NOT abort the access; it sets pending_flush and latches flush_pc.
  - The flush is taken on the mem_ready cycle; a later flush_req overwrites the latched PC.
REQ-025 IDLE & ex_multi_start SHALL output the EX code in that cycle and load cnt=N-1.
  - N<=1: stay IDLE, 1 stall cycle total.
  - Otherwise go to EX_BUSY.
REQ-026 EX_BUSY SHALL output the EX code every cycle and decrement cnt.
  - cnt==1: next state IDLE.
  - Total EX stall cycles = N.
REQ-027 flush_req in EX_BUSY SHALL abort the op: cnt<=0, go to FLUSH, stall=0 that cycle.
REQ-028 stallreq_id SHALL produce the ID code only in IDLE with no higher request; it is ignored in all other states.
REQ-029 FLUSH SHALL last exactly one cycle with flush=1, stall=0, and all requests ignored; then go to IDLE.
  - flush SHALL be 0 in all other states.
REQ-030 ex_multi_start or mem_req asserted outside IDLE SHALL be ignored; requesters hold them until served.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, cnt=0, pending_flush=0, flush=0, new_pc=0, timeout_err=0, and stall=0 regardless of inputs.
REQ-032 Reset asserted mid-EX_BUSY or mid-MEM_WAIT SHALL discard the operation; the first cycle after release behaves as IDLE.

Configuration
REQ-033 Macro PIPE_CTRL_TIMEOUT_EN defined:
  - A MEM_WAIT cycle counter is implemented.
  - After MEM_TIMEOUT consecutive cycles without mem_ready: timeout_err<=1 (sticky until reset), go to FLUSH with new_pc=EXC_VECTOR; any pending flush PC is dropped.
REQ-034 Macro undefined:
  - No counter is implemented; timeout_err is tied to 0.
  - MEM_WAIT waits indefinitely.

Verification
REQ-035 ex_multi_start=1, ex_multi_cycles=4 in IDLE -> stall=001111 for exactly 4 cycles, passing through EX_BUSY; then 000000.
REQ-036 mem_req=1, mem_ready low for 3 cycles then high -> stall=011111 for 3 cycles, 000000 on the ready cycle, then IDLE.
REQ-037 MEM_WAIT, flush_req pulse with flush_pc=0x80000100, mem_ready 2 cycles later -> flush=1 and new_pc=0x80000100 on the cycle after ready.
REQ-038 Same cycle in IDLE: flush_req, mem_req, stallreq_id -> stall=0, next cycle flush=1; no MEM_WAIT entered.
REQ-039 With PIPE_CTRL_TIMEOUT_EN, MEM_TIMEOUT=8, mem_ready held 0 -> after 8 stall cycles timeout_err=1, flush=1, new_pc=0xBFC00380.
REQ-040 rst pulsed low in EX_BUSY with cnt=5 -> stall=0 immediately; after release, stallreq_id=1 gives stall=000111.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, one-cycle flush with redirect PC, multi-cycle EX and MEM wait.
// Optional MEM_WAIT watchdog is built when PIPE_CTRL_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | no multi-cycle hazard active; arbitrates incoming requests
// EX_BUSY  | multi-cycle EX op running, counting down remaining stall cycles
// MEM_WAIT | data access outstanding, waiting for mem_ready
// FLUSH    | one-cycle flush pulse, new_pc valid
module pipe_ctrl #(
    parameter int          EX_CNT_W    = 5,
    parameter int          MEM_TIMEOUT = 64,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_multi_start,
    input  logic [EX_CNT_W-1:0] ex_multi_cycles,
    input  logic                mem_req,
    input  logic                mem_ready,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic [1:0]          ctrl_state,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EX_BUSY  = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    state_t                state_q, state_nxt;
    logic [EX_CNT_W-1:0]   cnt_q, cnt_nxt;
    logic                  pend_q, pend_nxt;
    logic [31:0]           pend_pc_q, pend_pc_nxt;
    logic [31:0]           new_pc_q, new_pc_nxt;
    logic [5:0]            stall_fsm;
    logic [EX_CNT_W-1:0]   ex_len;
    logic                  tmo_hit;

    // A zero-length op still costs one stall cycle.
    assign ex_len = (ex_multi_cycles == '0) ? EX_CNT_W'(1) : ex_multi_cycles;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             to_q;

    // Reloaded every IDLE cycle so it counts from the MEM stall issued in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_q == IDLE) begin
            tmo_q <= TMO_W'(MEM_TIMEOUT - 1);
        end else if (state_q == MEM_WAIT && tmo_q != '0) begin
            tmo_q <= tmo_q - TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q == MEM_WAIT) && !mem_ready && (tmo_q <= TMO_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q <= 1'b0;
        end else if (tmo_hit) begin
            to_q <= 1'b1;
        end
    end

    assign timeout_err = to_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{EXC_VECTOR, 32'(MEM_TIMEOUT)};
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            new_pc_q  <= '0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            pend_q    <= pend_nxt;
            pend_pc_q <= pend_pc_nxt;
            new_pc_q  <= new_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        pend_nxt    = pend_q;
        pend_pc_nxt = pend_pc_q;
        new_pc_nxt  = new_pc_q;
        stall_fsm   = STALL_NONE;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_nxt  = FLUSH;
                    new_pc_nxt = flush_pc;
                end else if (mem_req && !mem_ready) begin
                    stall_fsm = STALL_MEM;
                    state_nxt = MEM_WAIT;
                end else if (ex_multi_start) begin
                    stall_fsm = STALL_EX;
                    cnt_nxt   = ex_len - EX_CNT_W'(1);
                    if (ex_len != EX_CNT_W'(1)) begin
                        state_nxt = EX_BUSY;
                    end
                end else if (stallreq_id) begin
                    stall_fsm = STALL_ID;
                end
            end
            EX_BUSY: begin
                if (flush_req) begin
                    cnt_nxt    = '0;
                    state_nxt  = FLUSH;
                    new_pc_nxt = flush_pc;
                end else begin
                    stall_fsm = STALL_EX;
                    cnt_nxt   = cnt_q - EX_CNT_W'(1);
                    if (cnt_q <= EX_CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    pend_nxt = 1'b0;
                    if (flush_req) begin
                        state_nxt  = FLUSH;
                        new_pc_nxt = flush_pc;
                    end else if (pend_q) begin
                        state_nxt  = FLUSH;
                        new_pc_nxt = pend_pc_q;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (tmo_hit) begin
                    // Watchdog redirect supersedes any flush that was waiting on this access.
                    stall_fsm  = STALL_MEM;
                    pend_nxt   = 1'b0;
                    state_nxt  = FLUSH;
                    new_pc_nxt = EXC_VECTOR;
                end else begin
                    stall_fsm = STALL_MEM;
                    if (flush_req) begin
                        pend_nxt    = 1'b1;
                        pend_pc_nxt = flush_pc;
                    end
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall      = rst ? stall_fsm : STALL_NONE;
    assign flush      = (state_q == FLUSH);
    assign new_pc     = new_pc_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expectations go through a scoreboard queue and are
// checked with immediate assertions shortly after the falling edge.
module tb_pipe_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EX   = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_FL   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        ex_multi_start;
    logic [4:0]  ex_multi_cycles;
    logic        mem_req;
    logic        mem_ready;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [1:0]  ctrl_state;
    logic        timeout_err;

    typedef struct packed {
        logic [5:0]  stall;
        logic [1:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        chk_pc;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_to = 1'b0;

    pipe_ctrl #(
        .EX_CNT_W   (5),
        .MEM_TIMEOUT(8),
        .EXC_VECTOR (32'hBFC00380)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .ex_multi_start (ex_multi_start),
        .ex_multi_cycles(ex_multi_cycles),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .ctrl_state     (ctrl_state),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs are already driven for this cycle; record what this cycle must show, then check it.
    task automatic cyc(input string tag, input logic [5:0] s, input logic [1:0] st,
                       input logic fl, input logic [31:0] pc, input logic chk_pc);
        exp_t e;
        sb.push_back({s, st, fl, pc, chk_pc, exp_to});
        #1;
        e = sb.pop_front();
        checks++;
        assert (stall === e.stall) else begin
            errors++;
            $error("FAIL %s stall: got %b want %b", tag, stall, e.stall);
        end
        checks++;
        assert (ctrl_state === e.st) else begin
            errors++;
            $error("FAIL %s state: got %0d want %0d", tag, ctrl_state, e.st);
        end
        checks++;
        assert (flush === e.fl) else begin
            errors++;
            $error("FAIL %s flush: got %b want %b", tag, flush, e.fl);
        end
        checks++;
        assert (timeout_err === e.to) else begin
            errors++;
            $error("FAIL %s timeout_err: got %b want %b", tag, timeout_err, e.to);
        end
        if (e.chk_pc) begin
            checks++;
            assert (new_pc === e.pc) else begin
                errors++;
                $error("FAIL %s new_pc: got %h want %h", tag, new_pc, e.pc);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        stallreq_id = 1'b1;
        ex_multi_start = 1'b1;
        ex_multi_cycles = 5'd4;
        mem_req = 1'b1;
        mem_ready = 1'b0;
        flush_req = 1'b0;
        flush_pc = 32'h0;
        @(negedge clk);

        // Reset holds everything quiet even with requests asserted
        cyc("reset", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b1);
        stallreq_id = 0; ex_multi_start = 0; mem_req = 0;
        rst = 1'b1;
        cyc("idle", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b1);

        stallreq_id = 1;
        cyc("id_stall", S_ID, ST_IDLE, 1'b0, 32'h0, 1'b0);
        stallreq_id = 0;

        // EX op N=4: four EX stall cycles, with late MEM/ID requests ignored
        ex_multi_start = 1; ex_multi_cycles = 5'd4;
        cyc("ex4_c1", S_EX, ST_IDLE, 1'b0, 32'h0, 1'b0);
        ex_multi_start = 0;
        cyc("ex4_c2", S_EX, ST_EX, 1'b0, 32'h0, 1'b0);
        mem_req = 1; stallreq_id = 1;
        cyc("ex4_c3", S_EX, ST_EX, 1'b0, 32'h0, 1'b0);
        mem_req = 0; stallreq_id = 0;
        cyc("ex4_c4", S_EX, ST_EX, 1'b0, 32'h0, 1'b0);
        cyc("ex4_done", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // N=0 behaves as a single stall cycle
        ex_multi_start = 1; ex_multi_cycles = 5'd0;
        cyc("ex0_c1", S_EX, ST_IDLE, 1'b0, 32'h0, 1'b0);
        ex_multi_start = 0;
        cyc("ex0_done", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // MEM access, ready after three low cycles
        mem_req = 1; mem_ready = 0;
        cyc("mem_c1", S_MEM, ST_IDLE, 1'b0, 32'h0, 1'b0);
        cyc("mem_c2", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        cyc("mem_c3", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_ready = 1;
        cyc("mem_rdy", S_NONE, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_req = 0; mem_ready = 0;
        cyc("mem_done", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        mem_req = 1; mem_ready = 1;
        cyc("mem_hit", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);
        mem_req = 0; mem_ready = 0;
        cyc("mem_hit_after", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // Flush during MEM_WAIT is deferred to the ready cycle
        mem_req = 1;
        cyc("pf_c1", S_MEM, ST_IDLE, 1'b0, 32'h0, 1'b0);
        flush_req = 1; flush_pc = 32'h80000100;
        cyc("pf_flushreq", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        flush_req = 0; flush_pc = 32'h0;
        cyc("pf_wait", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_ready = 1;
        cyc("pf_rdy", S_NONE, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_req = 0; mem_ready = 0;
        cyc("pf_flush", S_NONE, ST_FL, 1'b1, 32'h80000100, 1'b1);
        cyc("pf_idle", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // A later pending flush overwrites the latched PC
        mem_req = 1;
        cyc("ow_c1", S_MEM, ST_IDLE, 1'b0, 32'h0, 1'b0);
        flush_req = 1; flush_pc = 32'h0000A000;
        cyc("ow_a", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        flush_pc = 32'h0000B000;
        cyc("ow_b", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        flush_req = 0; mem_ready = 1;
        cyc("ow_rdy", S_NONE, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_req = 0; mem_ready = 0;
        cyc("ow_flush", S_NONE, ST_FL, 1'b1, 32'h0000B000, 1'b1);
        cyc("ow_idle", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // Flush wins over MEM and ID in IDLE; FLUSH ignores requests
        flush_req = 1; mem_req = 1; stallreq_id = 1; flush_pc = 32'h00001234;
        cyc("prio", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);
        flush_req = 0; mem_req = 0;
        cyc("prio_flush", S_NONE, ST_FL, 1'b1, 32'h00001234, 1'b1);
        cyc("prio_after", S_ID, ST_IDLE, 1'b0, 32'h0, 1'b0);
        stallreq_id = 0;

        // Flush aborts a running EX op
        ex_multi_start = 1; ex_multi_cycles = 5'd6;
        cyc("exab_c1", S_EX, ST_IDLE, 1'b0, 32'h0, 1'b0);
        ex_multi_start = 0;
        cyc("exab_c2", S_EX, ST_EX, 1'b0, 32'h0, 1'b0);
        flush_req = 1; flush_pc = 32'h00000040;
        cyc("exab_req", S_NONE, ST_EX, 1'b0, 32'h0, 1'b0);
        flush_req = 0;
        cyc("exab_flush", S_NONE, ST_FL, 1'b1, 32'h00000040, 1'b1);
        cyc("exab_idle", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);

        // Reset in EX_BUSY with cnt=5 drops the op immediately
        ex_multi_start = 1; ex_multi_cycles = 5'd7;
        cyc("exrst_c1", S_EX, ST_IDLE, 1'b0, 32'h0, 1'b0);
        ex_multi_start = 0;
        cyc("exrst_c2", S_EX, ST_EX, 1'b0, 32'h0, 1'b0);
        rst = 0;
        cyc("exrst_rst", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b1);
        rst = 1; stallreq_id = 1;
        cyc("exrst_id", S_ID, ST_IDLE, 1'b0, 32'h0, 1'b1);
        stallreq_id = 0;

`ifdef PIPE_CTRL_TIMEOUT_EN
        // Eight MEM stall cycles, then watchdog flush to the exception vector
        mem_req = 1;
        cyc("to_c1", S_MEM, ST_IDLE, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            flush_req = (i == 2); flush_pc = 32'h00001111;
            cyc("to_wait", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        end
        flush_req = 0; mem_req = 0;
        exp_to = 1'b1;
        cyc("to_flush", S_NONE, ST_FL, 1'b1, 32'hBFC00380, 1'b1);
        cyc("to_sticky", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);
        rst = 0; exp_to = 1'b0;
        cyc("to_rst", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b1);
        rst = 1;
`else
        // Without the watchdog MEM_WAIT waits indefinitely
        mem_req = 1;
        cyc("long_c1", S_MEM, ST_IDLE, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc("long_wait", S_MEM, ST_MEM, 1'b0, 32'h0, 1'b0);
        end
        mem_ready = 1;
        cyc("long_rdy", S_NONE, ST_MEM, 1'b0, 32'h0, 1'b0);
        mem_req = 0; mem_ready = 0;
        cyc("long_done", S_NONE, ST_IDLE, 1'b0, 32'h0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
